bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
- Digit-serial packed-BCD subtractor. Computes A − B − Bin over DIGITS BCD digits, processing one digit per clock, least-significant digit first.
- Produces a ten's-complement BCD difference and a borrow-out.
- Inverse-operation companion to the team's BCD adder. Used where BCD operands are decremented or compared without converting to binary.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
- DIGITS, 2, number of BCD digits per operand; operand width is 4*DIGITS bits.
- CNT_W, $clog2(DIGITS+1), digit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0]
- b  input  4*DIGITS  subtrahend, packed BCD
- bin  input  1  borrow-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  4*DIGITS  difference, packed BCD
- bout  output  1  borrow-out; 1 means A−B−Bin < 0 and d is the ten's complement
- err  output  1  an operand digit was > 9

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is asynchronous and active-high: assert takes effect immediately; release is sampled on clk.
- Reset values:
  - State IDLE; in_ready=1; out_valid=0; d=0; bout=0; err=0.
  - Internal operand registers, borrow and counter are all 0.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On in_valid=1 at a clock edge: capture a, b and bin; set err if any digit of a or b is > 9; clear the counter; go to RUN.
  - RUN:
    - in_ready=0.
    - Each edge processes digit index cnt with t = a_digit − b_digit − borrow, evaluated as 5-bit signed.
    - If t < 0: digit = t+10 and borrow=1. Otherwise digit = t and borrow=0.
    - The digit is written to result slot cnt; cnt increments.
    - After the edge that processes digit DIGITS−1, go to DONE.
  - DONE:
    - out_valid=1; d, bout and err are held stable.
    - On out_ready=1 at an edge, go to IDLE (out_valid drops).
    - With out_ready=0, stay in DONE indefinitely.
- Latency and throughput:
  - out_valid rises exactly DIGITS clock edges after the accepting edge.
  - Minimum spacing between accepts is DIGITS+2 cycles.
  - in_ready is never high in the same cycle as out_valid.
- Invalid digits: if err=1, the block still spends DIGITS cycles in RUN (fixed latency), then presents d=0 and bout=0 with err=1.
- bout equals the final borrow out of digit DIGITS−1.
- Ignored inputs: in_valid while busy (RUN or DONE) is ignored and no operands are captured. out_ready outside DONE has no effect.
- Reset mid-operation: returns to IDLE immediately and all outputs take their reset values; the in-flight result is discarded.
- Output source: d, bout and err come directly from registers with no combinational path from any input. in_ready and out_valid decode the state register only.

Decomposition:
- Package bcd_pkg holds:
  - BCD_DIGIT_W=4 and BCD_MAX=9
  - typedef bcd_digit_t (logic [3:0])
  - enum sub_state_t {IDLE, RUN, DONE}
- Sub-module bcd_digit_sub: combinational, one digit.
  - Inputs: a, b (bcd_digit_t) and bin.
  - Outputs: diff (bcd_digit_t) and bout.
  - Implements the t/+10 rule above. It is instantiated once and fed by a digit mux indexed by cnt.

Test Plan:
- Basic subtract, DIGITS=2: accept a=0x47, b=0x25, bin=0 → d=0x22, bout=0, err=0. out_valid rises exactly 2 edges after the accept; in_ready=0 in between.
- Negative result: a=0x25, b=0x47, bin=0 → d=0x78, bout=1 (ten's complement of −22).
- Borrow chain and borrow-in: a=0x90, b=0x09, bin=0 → d=0x81, bout=0. Then a=0x00, b=0x00, bin=1 → d=0x99, bout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid with new operands → d, bout and out_valid stay stable, no capture occurs, in_ready=0. When out_ready=1, return to IDLE and in_ready=1 the next cycle.
- Invalid digit: a=0x3A, b=0x01 → after 2 cycles out_valid=1, err=1, d=0x00, bout=0. The next valid operation clears err.
- Reset mid-RUN: assert rst one cycle after an accept, asynchronously between edges → out_valid=0, d=0, bout=0, in_ready=1 immediately. A following operation a=0x10, b=0x01 → d=0x09, bout=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the digit-serial arithmetic blocks.
// Digit type, limits, FSM state encoding and a digit range check.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    function automatic logic bcd_bad(input bcd_digit_t x);
        return x > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of subtraction: diff = a - b - bin,
// wrapped back into 0..9 with a borrow when negative.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t diff,
    output logic       bout
);

    logic [4:0] t;
    logic [4:0] adj;

    // 5-bit signed difference; bit 4 set means the digit went negative
    always_comb begin
        t    = {1'b0, a} - {1'b0, b} - {4'd0, bin};
        adj  = t + 5'd10;
        bout = t[4];
        diff = t[4] ? adj[3:0] : t[3:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, LSD first, one digit per clock.
// Ten's-complement result with borrow-out; valid/ready on both sides.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int CNT_W  = $clog2(DIGITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] d,
    output logic                bout,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    sub_state_t       state;
    logic [W-1:0]     ra;
    logic [W-1:0]     rb;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    bcd_digit_t       da;
    bcd_digit_t       db;
    bcd_digit_t       ddiff;
    logic             dbout;
    logic             bad;
    logic             last;

    // Select the current digit pair from the captured operands
    always_comb begin
        da = '0;
        db = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                da = ra[i*4 +: 4];
                db = rb[i*4 +: 4];
            end
        end
    end

    // Flag any non-decimal digit in the incoming operands
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_bad(a[i*4 +: 4]) || bcd_bad(b[i*4 +: 4]))
                bad = 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(DIGITS - 1));

    bcd_digit_sub u_dsub (
        .a    (da),
        .b    (db),
        .bin  (borrow),
        .diff (ddiff),
        .bout (dbout)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Capture, per-digit iteration and result hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra     <= a;
                        rb     <= b;
                        borrow <= bin;
                        err    <= bad;
                        d      <= '0;
                        bout   <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    borrow <= dbout;
                    cnt    <= cnt + CNT_W'(1);
                    if (!err) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (cnt == CNT_W'(i))
                                d[i*4 +: 4] <= ddiff;
                        end
                    end
                    if (last) begin
                        bout  <= err ? 1'b0 : dbout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for the digit-serial BCD subtractor (DIGITS=2).
// Driver pushes expected results; a negedge monitor pops on handshake.
module tb_bcd_serial_subtractor;

    logic       clk = 0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       bout;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       err;
    } exp_t;

    exp_t sb[$];

    bcd_serial_subtractor #(.DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare against the scoreboard on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual d=%0h required none", d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (d !== e.d || bout !== e.bout || err !== e.err) begin
                    errors++;
                    $display("FAIL result actual d=%0h bout=%0b err=%0b required d=%0h bout=%0b err=%0b",
                             d, bout, err, e.d, e.bout, e.err);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_in_ready", in_ready, 1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tbin, input logic [7:0] ed,
                          input logic eb, input logic ee);
        wait_ready();
        a = ta;
        b = tb_;
        bin = tbin;
        in_valid = 1;
        sb.push_back('{ed, eb, ee});
        @(posedge clk);
        #1 in_valid = 0;
        chk("busy_in_ready", in_ready, 0);
        @(posedge clk);
        #1 chk("early_valid", out_valid, 0);
        chk("run_in_ready", in_ready, 0);
        @(posedge clk);
        #1 chk("latency_valid", out_valid, 1);
        chk("done_in_ready", in_ready, 0);
        @(posedge clk);
        #1 chk("back_to_idle", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1;
        in_valid = 0;
        a = 0;
        b = 0;
        bin = 0;
        out_ready = 1;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 0;

        run_op(8'h47, 8'h25, 0, 8'h22, 0, 0);
        run_op(8'h25, 8'h47, 0, 8'h78, 1, 0);
        run_op(8'h90, 8'h09, 0, 8'h81, 0, 0);
        run_op(8'h00, 8'h00, 1, 8'h99, 1, 0);
        run_op(8'h99, 8'h99, 0, 8'h00, 0, 0);
        run_op(8'h00, 8'h01, 1, 8'h98, 1, 0);

        // Backpressure: hold result, new requests must be ignored
        wait_ready();
        out_ready = 0;
        a = 8'h63;
        b = 8'h28;
        bin = 0;
        in_valid = 1;
        sb.push_back('{8'h35, 1'b0, 1'b0});
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("bp_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1;
            a = 8'h11;
            b = 8'h11;
            @(posedge clk);
            #1 chk("bp_hold_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_d", d, 8'h35);
            chk("bp_bout", bout, 0);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1 chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        @(posedge clk);
        #1 chk("bp_no_capture", in_ready, 1);

        // Invalid digit, then a clean operation clears err
        run_op(8'h3A, 8'h01, 0, 8'h00, 0, 1);
        run_op(8'h50, 8'h25, 0, 8'h25, 0, 0);

        // Asynchronous reset in the middle of RUN
        wait_ready();
        a = 8'h55;
        b = 8'h11;
        bin = 0;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(posedge clk);
        #2 rst = 1;
        #1 chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_d", d, 0);
        chk("mid_rst_bout", bout, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        rst = 0;
        run_op(8'h10, 8'h01, 0, 8'h09, 0, 0);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
